// File: rtl/button_event_pkg.sv
// button_event_pkg: register offsets, event/STATUS field positions and event word builder
package button_event_pkg;
   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_EVENT = 2'd1;
   localparam int EV_VALID = 31;
   localparam int EV_EDGE = 8;
   localparam int EV_IDX_MSB = 7;
   localparam int ST_COUNT_LSB = 16;
   localparam int ST_OVF = 24;
   localparam int ST_EMPTY = 25;
   typedef enum logic {EDGE_RELEASE = 1'b0, EDGE_PRESS = 1'b1} edge_e;
   function automatic logic [31:0] ev_word(input logic press, input logic [7:0] idx);
      logic [31:0] w;
      w = '0;
      w[EV_VALID] = 1'b1;
      w[EV_EDGE] = press;
      w[EV_IDX_MSB:0] = idx;
      return w;
   endfunction
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: 2-flop synchroniser, hold-time debounce and one-cycle edge pulse for one button
module btn_debouncer
   import button_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  btn_n,
   output logic  stable,
   output logic  edge_pulse,
   output edge_e edge_type
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic pressed;
   assign pressed = ~sync[1];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync <= 2'b11;
         stable <= 1'b0;
         cnt <= '0;
         edge_pulse <= 1'b0;
         edge_type <= EDGE_RELEASE;
      end else begin
         sync <= {sync[0], btn_n};
         edge_pulse <= 1'b0;
         if (pressed == stable) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            stable <= pressed;
            edge_pulse <= 1'b1;
            edge_type <= edge_e'(pressed);
         end else cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/button_event_unit.sv
// button_event_unit: debounced buttons -> press/release event FIFO with STATUS/EVENT bus registers
module button_event_unit
   import button_event_pkg::*;
#(
   parameter int NUM_BTNS = 2,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_n,
   input  logic                ren,
   input  logic [31:0]         address,
   output logic [31:0]         data_out,
   output logic                irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   logic [NUM_BTNS-1:0] stable, pulse, etype, pending, ptype, grant;
   logic [7:0] sel_idx;
   logic sel_type, push, pop, do_push, empty, full, rd_status, rd_event, ovf, ovf_nxt;
   logic [8:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, cnt_nxt;
   logic [31:0] status, rdata;
   logic addr_unused;
   assign addr_unused = ^{address[31:4], address[1:0]};
   for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
      btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk(clk),
         .reset(reset),
         .btn_n(btn_n[b]),
         .stable(stable[b]),
         .edge_pulse(pulse[b]),
         .edge_type(etype[b])
      );
   end
   // descending scan so the lowest pending index wins
   always_comb begin
      grant = '0;
      sel_idx = '0;
      sel_type = 1'b0;
      for (int i = NUM_BTNS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            grant = '0;
            grant[i] = 1'b1;
            sel_idx = 8'(i);
            sel_type = ptype[i];
         end
      end
   end
   assign push = |pending;
   assign rd_status = ren && address[3:2] == REG_STATUS;
   assign rd_event = ren && address[3:2] == REG_EVENT;
   assign empty = count == '0;
   assign full = count == CW'(FIFO_DEPTH);
   assign pop = rd_event && !empty;
   assign do_push = push && (!full || pop);
   assign cnt_nxt = count + CW'(do_push) - CW'(pop);
   assign ovf_nxt = (push && full && !pop) || (ovf && !rd_status);
   always_comb begin
      status = '0;
      status[NUM_BTNS-1:0] = stable;
      status[ST_COUNT_LSB +: 5] = 5'(count);
      status[ST_OVF] = ovf;
      status[ST_EMPTY] = empty;
      rdata = rd_status ? status : (rd_event && !empty) ? ev_word(mem[rd_ptr][8], mem[rd_ptr][7:0]) : '0;
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {sel_type, sel_idx};
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
         ptype <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         ovf <= 1'b0;
         data_out <= '0;
         irq <= 1'b0;
      end else begin
         pending <= (pending & ~grant) | pulse;
         ptype <= (ptype & ~pulse) | (etype & pulse);
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= cnt_nxt;
         ovf <= ovf_nxt;
         if (ren) data_out <= rdata;
         irq <= (cnt_nxt != '0) | ovf_nxt;
      end
   end
endmodule

// File: tb/tb_button_event_unit.sv
// tb_button_event_unit: table-driven vectors plus overflow, coincident push/pop and reset sequences
module tb_button_event_unit;
   typedef struct {
      logic [1:0]  btn;
      int          hold;
      logic        rd;
      logic [1:0]  reg_sel;
      logic [31:0] exp_data;
      logic        exp_irq;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic ren = 1'b0;
   logic [1:0] btn_n = 2'b11;
   logic [31:0] address = '0;
   logic [31:0] data_out;
   logic irq;
   int n_cmp = 0;
   int n_bad = 0;
   vec_t v[$];
   button_event_unit #(.NUM_BTNS(2), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
      .clk(clk),
      .reset(reset),
      .btn_n(btn_n),
      .ren(ren),
      .address(address),
      .data_out(data_out),
      .irq(irq)
   );
   always #5 clk = ~clk;
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic rd_chk(input string name, input logic [1:0] r, input logic [31:0] exp, input logic exp_irq);
      ren = 1'b1;
      address = {28'd0, r, 2'b00};
      tick(1);
      ren = 1'b0;
      address = '0;
      check(name, data_out, exp);
      check({name, "_irq"}, 32'(irq), 32'(exp_irq));
   endtask
   initial begin
      v.push_back('{2'b11, 2, 1'b1, 2'd0, 32'h0200_0000, 1'b0});
      v.push_back('{2'b10, 3, 1'b0, 2'd0, 32'h0000_0000, 1'b0});
      v.push_back('{2'b11, 8, 1'b1, 2'd0, 32'h0200_0000, 1'b0});
      v.push_back('{2'b10, 10, 1'b1, 2'd0, 32'h0001_0001, 1'b1});
      v.push_back('{2'b10, 0, 1'b1, 2'd1, 32'h8000_0100, 1'b0});
      v.push_back('{2'b10, 0, 1'b1, 2'd0, 32'h0200_0001, 1'b0});
      v.push_back('{2'b10, 0, 1'b1, 2'd1, 32'h0000_0000, 1'b0});
      v.push_back('{2'b11, 10, 1'b1, 2'd0, 32'h0001_0000, 1'b1});
      v.push_back('{2'b11, 0, 1'b1, 2'd1, 32'h8000_0000, 1'b0});
      v.push_back('{2'b00, 10, 1'b1, 2'd0, 32'h0002_0003, 1'b1});
      v.push_back('{2'b00, 0, 1'b1, 2'd1, 32'h8000_0100, 1'b1});
      v.push_back('{2'b00, 0, 1'b1, 2'd1, 32'h8000_0101, 1'b0});
      v.push_back('{2'b11, 10, 1'b1, 2'd0, 32'h0002_0000, 1'b1});
      v.push_back('{2'b11, 0, 1'b1, 2'd1, 32'h8000_0000, 1'b1});
      v.push_back('{2'b11, 0, 1'b1, 2'd1, 32'h8000_0001, 1'b0});
      v.push_back('{2'b11, 0, 1'b1, 2'd2, 32'h0000_0000, 1'b0});
      v.push_back('{2'b11, 0, 1'b1, 2'd3, 32'h0000_0000, 1'b0});
      tick(2);
      check("reset_data", data_out, 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      reset = 1'b1;
      tick(2);
      foreach (v[k]) begin
         btn_n = v[k].btn;
         tick(v[k].hold);
         if (v[k].rd) rd_chk($sformatf("vec%0d", k), v[k].reg_sel, v[k].exp_data, v[k].exp_irq);
      end
      // five edges without reads: the fifth (a press of btn 0) is dropped
      for (int e = 0; e < 5; e++) begin
         btn_n = (e % 2 == 0) ? 2'b10 : 2'b11;
         tick(10);
      end
      check("ovf_irq", 32'(irq), 32'h1);
      rd_chk("ovf_status1", 2'd0, 32'h0104_0001, 1'b1);
      rd_chk("ovf_status2", 2'd0, 32'h0004_0001, 1'b1);
      // release edge lands in the FIFO on the same edge as the EVENT pop
      btn_n = 2'b11;
      tick(7);
      rd_chk("coinc_ev", 2'd1, 32'h8000_0100, 1'b1);
      rd_chk("coinc_status", 2'd0, 32'h0004_0000, 1'b1);
      rd_chk("drain0", 2'd1, 32'h8000_0000, 1'b1);
      rd_chk("drain1", 2'd1, 32'h8000_0100, 1'b1);
      rd_chk("drain2", 2'd1, 32'h8000_0000, 1'b1);
      rd_chk("drain3", 2'd1, 32'h8000_0000, 1'b0);
      rd_chk("drain_empty", 2'd1, 32'h0000_0000, 1'b0);
      btn_n = 2'b01;
      tick(10);
      btn_n = 2'b00;
      tick(10);
      rd_chk("pre_rst_status", 2'd0, 32'h0002_0003, 1'b1);
      btn_n = 2'b01;
      #2 reset = 1'b0;
      #1;
      check("mid_rst_data", data_out, 32'h0);
      check("mid_rst_irq", 32'(irq), 32'h0);
      tick(3);
      reset = 1'b1;
      tick(10);
      rd_chk("post_rst_status", 2'd0, 32'h0001_0002, 1'b1);
      rd_chk("post_rst_ev", 2'd1, 32'h8000_0101, 1'b0);
      rd_chk("post_rst_empty", 2'd0, 32'h0200_0002, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
